// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the iterative 16x16 multiplier: operand width,
// iteration count and the controller state encoding.
package mul16_seq_pkg;

  localparam int OP_W     = 16;
  localparam int MUL_ITER = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    MUL    = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/mul16_seq_if.sv
// Pipeline-side handshake bundle for mul16_seq: request, operands, status
// and product.
interface mul16_seq_if;
  import mul16_seq_pkg::*;

  logic                  start;
  logic                  sign;
  logic                  flush;
  logic [OP_W-1:0]       a;
  logic [OP_W-1:0]       b;
  logic                  busy;
  logic                  done;
  logic [2*OP_W-1:0]     product;

  modport master (
    output start, sign, flush, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, sign, flush, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/cla16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups whose group
// generate/propagate terms feed a fully expanded second lookahead level.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ofl
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [16:0] c;

  // Every carry is written directly in terms of g/p/cin so no carry depends on another bit of its own vector.
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end

    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & cin);

    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
               | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
    c[16] = gc[4];

    sum  = p ^ c[15:0];
    cout = c[16];
    ofl  = c[16] ^ c[15];
  end

endmodule

// File: rtl/mul16_seq.sv
// Fixed-latency (21 cycle) sign-magnitude shift-add multiplier that funnels
// every addition through one shared cla16.
module mul16_seq
  import mul16_seq_pkg::*;
#(
  parameter int WIDTH = OP_W
) (
  input  logic       clk,
  input  logic       rst,
  mul16_seq_if.slave bus
);

  if (WIDTH != 16) begin : g_width_check
    $error("mul16_seq: WIDTH must be 16 to match cla16");
  end

  state_t             state_q;
  state_t             state_d;
  logic               accept;
  logic               busy;
  logic               done;

  logic [WIDTH-1:0]   ra;
  logic [WIDTH-1:0]   rb;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               rsign;
  logic               neg;
  logic               k;
  logic [3:0]         cnt;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   add_x;
  logic [WIDTH-1:0]   add_y;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               add_ofl_unused;

  logic [WIDTH:0]     pp;
  logic [WIDTH-1:0]   mag_b;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A flush only matters while busy; in IDLE it also swallows a coincident start.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept  = 1'b1;
          state_d = NEG_A;
        end
      end
      NEG_A: begin
        busy    = 1'b1;
        state_d = NEG_B;
      end
      NEG_B: begin
        busy    = 1'b1;
        state_d = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == 4'(MUL_ITER - 1)) state_d = NEG_LO;
      end
      NEG_LO: begin
        busy    = 1'b1;
        state_d = NEG_HI;
      end
      NEG_HI: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_d = NEG_A;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (busy && bus.flush) state_d = IDLE;
  end

  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (state_q)
      NEG_A: begin
        add_x   = ~ra;
        add_cin = 1'b1;
      end
      NEG_B: begin
        add_x   = ~rb;
        add_cin = 1'b1;
      end
      MUL: begin
        add_x = hi;
        add_y = ra;
      end
      NEG_LO: begin
        add_x   = ~lo;
        add_cin = 1'b1;
      end
      NEG_HI: begin
        add_x   = ~hi;
        add_cin = k;
      end
      default: ;
    endcase
  end

  cla16 u_cla16 (
    .a    (add_x),
    .b    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .ofl  (add_ofl_unused)
  );

  assign pp    = lo[0] ? {add_cout, add_sum} : {1'b0, hi};
  assign mag_b = (rsign && rb[WIDTH-1]) ? add_sum : rb;

  // Operands become magnitudes first; the product sign is reapplied as a 32-bit negate split over two adder passes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra        <= '0;
      rb        <= '0;
      hi        <= '0;
      lo        <= '0;
      rsign     <= 1'b0;
      neg       <= 1'b0;
      k         <= 1'b0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            ra    <= bus.a;
            rb    <= bus.b;
            rsign <= bus.sign;
            neg   <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          end
        end
        NEG_A: begin
          if (rsign && ra[WIDTH-1]) ra <= add_sum;
        end
        NEG_B: begin
          rb  <= mag_b;
          hi  <= '0;
          lo  <= mag_b;
          cnt <= '0;
        end
        MUL: begin
          hi  <= pp[WIDTH:1];
          lo  <= {pp[0], lo[WIDTH-1:1]};
          cnt <= cnt + 4'd1;
        end
        NEG_LO: begin
          if (neg) begin
            lo <= add_sum;
            k  <= add_cout;
          end else begin
            k  <= 1'b0;
          end
        end
        NEG_HI: begin
          if (neg) hi <= add_sum;
          if (!bus.flush) product_q <= {(neg ? add_sum : hi), lo};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Randomized self-checking bench for mul16_seq: products come from plain
// integer multiplication, timing from the fixed 21-cycle handshake.
module tb_mul16_seq;
  import mul16_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] lastProd;

  mul16_seq_if bus ();

  mul16_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] refProduct(input logic [15:0] x, input logic [15:0] y,
                                              input logic s);
    longint sx;
    longint sy;
    longint full;
    sx   = s ? longint'($signed(x)) : longint'(x);
    sy   = s ? longint'($signed(y)) : longint'(y);
    full = sx * sy;
    return full[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Call only from an IDLE or DONE cycle; returns while in the DONE cycle.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                               input logic ts, input bit poke, input bit flushAtStart);
    logic [31:0] exp;
    exp       = refProduct(ta, tb, ts);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb;
    bus.sign  = ts;
    bus.flush = flushAtStart;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      checkOutput("busy window", {31'b0, bus.busy}, 32'd1);
      checkOutput("done early", {31'b0, bus.done}, 32'd0);
      if (poke && c == 6) begin
        bus.start = 1'b1;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.sign  = ~ts;
      end else if (poke && c == 7) begin
        bus.start = 1'b0;
      end
      tick();
    end
    checkOutput("done pulse", {31'b0, bus.done}, 32'd1);
    checkOutput("busy at done", {31'b0, bus.busy}, 32'd0);
    checkOutput("product", bus.product, exp);
    lastProd = exp;
  endtask

  logic [15:0] da [6] = '{16'h0003, 16'hFFFF, 16'hFFFD, 16'hFFFF, 16'h8000, 16'h8000};
  logic [15:0] db [6] = '{16'h0005, 16'hFFFF, 16'h0005, 16'hFFFF, 16'h8000, 16'h0001};
  logic        ds [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] corner [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] hold;

    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.flush = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    lastProd  = '0;
    rst       = 1'b1;
    repeat (3) tick();
    checkOutput("reset busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("reset done", {31'b0, bus.done}, 32'd0);
    checkOutput("reset product", bus.product, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle done", {31'b0, bus.done}, 32'd0);

    $display("[TB] directed operand set");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(da[i], db[i], ds[i], (i == 2), 1'b0);
      tick();
      checkOutput("done one-shot", {31'b0, bus.done}, 32'd0);
      checkOutput("product hold", bus.product, lastProd);
    end

    $display("[TB] flush mid-operation then restart");
    hold      = lastProd;
    bus.start = 1'b1;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.sign  = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    checkOutput("busy before flush", {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checkOutput("flush busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("flush done", {31'b0, bus.done}, 32'd0);
    checkOutput("flush product", bus.product, hold);
    tick();
    applyStimulus(16'd7, 16'd6, 1'b0, 1'b0, 1'b0);

    $display("[TB] flush in DONE ignored, then back-to-back");
    applyStimulus(16'hFFF0, 16'h0010, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    tick();

    $display("[TB] flush with start in IDLE drops the start");
    hold      = lastProd;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.a     = 16'h0009;
    bus.b     = 16'h0009;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checkOutput("dropped start busy", {31'b0, bus.busy}, 32'd0);
    for (int c = 0; c < 22; c++) begin
      checkOutput("dropped start done", {31'b0, bus.done}, 32'd0);
      tick();
    end
    checkOutput("dropped start product", bus.product, hold);

    $display("[TB] randomized operations");
    for (int n = 0; n < 24; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        checkOutput("rand idle done", {31'b0, bus.done}, 32'd0);
      end
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 1'b0);
    end
    tick();

    $display("[TB] reset during MUL");
    bus.start = 1'b1;
    bus.a     = 16'hABCD;
    bus.b     = 16'h1357;
    bus.sign  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    checkOutput("busy before reset", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid reset busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("mid reset done", {31'b0, bus.done}, 32'd0);
    checkOutput("mid reset product", bus.product, 32'd0);
    tick();
    applyStimulus(16'hABCD, 16'h1357, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("final done low", {31'b0, bus.done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
